player_motion_ctrl: RTL and testbench
=====================================

Name: player_motion_ctrl

Overview:
Parametrised successor to the horizontal player controller. It turns key codes into tick-paced horizontal motion of the player sprite. Each move looks up the collision map at the target position, not the current one. Map read latency, step size, bounds, tile codes and map address packing are all configurable. The block sits between the keyboard decoder and the sprite draw / collision-map ROM in the game layer.

Parameters:
X_W, 11, width of player_xpos
Y_W, 10, width of ypos
STEP, 1, pixels moved per accepted move (1..15)
X_MAX, 2000, largest legal xpos; must fit in X_W bits
TICK_CYCLES, 500000, cycles spent in WAIT after each move attempt (>=1)
MAP_LAT, 1, map ROM read latency in cycles (1..4)
MAP_SHIFT, 2, pixel-to-map-cell right shift applied to x and y
MAP_X_BITS, 9, low address bits holding the x cell
ADR_W, 16, map address width
RUN_AFTER, 8, consecutive same-direction moves before run mode (PLAYER_RUN_EN only)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
key  in  4  decoded key code (key_A = left, key_D = right, others = no move)
ypos  in  Y_W  current player y in pixels
door_open  in  1  1 = door tiles passable
map_pixel  in  4  collision-map tile code, valid MAP_LAT cycles after map_adr
map_adr  out  ADR_W  collision-map address
player_xpos  out  X_W  player x in pixels
direction  out  1  1 = facing right, 0 = facing left
busy  out  1  high in any state other than IDLE
blocked  out  1  one-cycle pulse when a move is rejected by a tile or a bound

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, player_xpos=0, direction=1, map_adr=0, blocked=0, counters=0.
  - Reset asserted mid-move abandons the move immediately; no partial xpos update.
- States: IDLE, LOOKUP, WAIT.
- IDLE:
  - Any key other than key_A/key_D: stay in IDLE.
  - key_D/key_A at edge E0: latch req_dir (1/0) and compute the target.
  - Right target: tgt = min(xpos+STEP, X_MAX). Left target: tgt = max(xpos-STEP, 0), computed without underflow (xpos<STEP gives 0).
  - At E0 register map_adr[MAP_X_BITS-1:0] = tgt>>MAP_SHIFT and upper bits = ypos>>MAP_SHIFT (truncated to fit), then enter LOOKUP.
- LOOKUP:
  - Lasts exactly MAP_LAT cycles; map_pixel is sampled on the last one, at edge E0+MAP_LAT.
  - A tile is blocking if map_pixel==WALL_CODE (4'h0), or map_pixel==DOOR_CODE (4'h4) with door_open=0.
  - Reversal rule: if req_dir!=direction, the move is allowed regardless of the tile (lets the player back out of a wall), but not past a bound.
  - Bound rule: a move is also blocked when tgt==xpos (already at the bound).
  - At E0+MAP_LAT: direction<=req_dir always.
  - At E0+MAP_LAT, allowed move: player_xpos<=tgt.
  - At E0+MAP_LAT, blocked move: xpos unchanged and blocked<=1 for exactly one cycle.
  - Then enter WAIT.
- WAIT:
  - Counts TICK_CYCLES cycles, then returns to IDLE. The counter resets to 0 on exit.
  - key is ignored during LOOKUP and WAIT.
- Held key: moves repeat every MAP_LAT+TICK_CYCLES+1 cycles.
- Key changes during LOOKUP have no effect; the latched req_dir is used.
- ypos is sampled only at E0.
- All outputs are registered; no combinational path from input to output.

Optional Feature:
PLAYER_RUN_EN
- Defined:
  - A run counter increments on each allowed move in the same direction as the previous one.
  - It clears on a reversal, a blocked move, or an IDLE cycle with no move key.
  - When run counter >= RUN_AFTER (saturating), the WAIT length becomes TICK_CYCLES>>1 (minimum 1).
  - Extra output port running (1 bit) is high while run mode is active; reset value 0.
- Undefined: WAIT is always TICK_CYCLES, and the running port is absent.

Decomposition:
- Shared package player_pkg:
  - state enum.
  - WALL_CODE and DOOR_CODE tile constants.
  - move-direction typedef.
- Key codes key_A/key_D stay in vga_pkg and are imported.
- One sub-module: tick_timer.
  - Loadable down-counter for WAIT.
  - Ports clk, rst, load, len, done.
  - Reused later by other paced game objects.

Test Plan:
- Params TICK_CYCLES=4, MAP_LAT=1, STEP=1; map returns 4'h1; key=key_D held from reset release.
  - Required: xpos 0->1->2->3 with a new step every 6 cycles, direction=1, blocked never asserts.
- Start at xpos=10, direction=1; map returns 4'h0; key=key_D.
  - Required: xpos stays 10; blocked pulses 1 cycle per attempt; map_adr low bits=2 (11>>2).
- Same position and wall; key=key_A.
  - Required: reversal allowed, xpos=9, direction=0.
- Door tile 4'h4 with door_open=0 and key_D.
  - Required: blocked.
- Door tile 4'h4 with door_open=1 and key_D.
  - Required: xpos increments.
- Left bound: xpos=0, key_A, direction=0, STEP=3.
  - Required: xpos stays 0, blocked pulses.
- Right bound: xpos=X_MAX-1, STEP=3, key_D.
  - Required: xpos=X_MAX on the first move; the next attempt is blocked.
- Assert rst one cycle during LOOKUP with xpos=5.
  - Required: outputs return at once to xpos=0, direction=1, busy=0, blocked=0.
- With PLAYER_RUN_EN, RUN_AFTER=2, key_D held.
  - Required: the first 2 moves are spaced 6 cycles, later moves 4 cycles, and running=1.
  - Releasing the key for one IDLE cycle clears running.

Source files
------------

// File: rtl/player_pkg.sv
// Player-object shared types: FSM states, move direction, collision tile
// codes and the tile-blocking helper.
package player_pkg;
  typedef enum logic [1:0] {IDLE, LOOKUP, WAIT} state_e;
  typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_e;

  localparam logic [3:0] WALL_CODE = 4'h0;
  localparam logic [3:0] DOOR_CODE = 4'h4;

  function automatic logic tile_blocks(input logic [3:0] pix, input logic door_open);
    return (pix == WALL_CODE) || ((pix == DOOR_CODE) && !door_open);
  endfunction
endpackage

// File: rtl/vga_pkg.sv
// Shared VGA/game-layer definitions.
// Holds the decoded keyboard codes consumed by the game-layer controllers.
package vga_pkg;
  localparam logic [3:0] key_A = 4'hA;  // move left
  localparam logic [3:0] key_D = 4'hD;  // move right
endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter used to pace game objects.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   load     - load len into the counter
//   len      - number of cycles to count (>=1)
//   done     - high on the last counted cycle; the counter reaches 0 after it
module tick_timer #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] len,
  output logic         done
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt_q <= '0;
    else if (load)          cnt_q <= len;
    else if (cnt_q != '0)   cnt_q <= cnt_q - W'(1);
  end

  assign done = (cnt_q == W'(1));
endmodule

// File: rtl/player_motion_ctrl.sv
// Horizontal player motion controller.
// Turns key codes into tick-paced moves of the player sprite, checking the
// collision map at the target position before committing each move.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   key          - decoded key code (key_A left, key_D right)
//   ypos         - player y in pixels, sampled when a move starts
//   door_open    - door tiles are passable when 1
//   map_pixel    - tile code, valid MAP_LAT cycles after map_adr
//   map_adr      - collision-map address {y cell, x cell}
//   player_xpos  - player x in pixels
//   direction    - 1 facing right, 0 facing left
//   busy         - high outside IDLE
//   blocked      - one-cycle pulse on a rejected move
//   running      - run mode active (only with PLAYER_RUN_EN defined)
// Optional feature macro: PLAYER_RUN_EN (run mode shortens WAIT).
module player_motion_ctrl
  import vga_pkg::*;
  import player_pkg::*;
#(
  parameter int X_W         = 11,
  parameter int Y_W         = 10,
  parameter int STEP        = 1,
  parameter int X_MAX       = 2000,
  parameter int TICK_CYCLES = 500000,
  parameter int MAP_LAT     = 1,
  parameter int MAP_SHIFT   = 2,
  parameter int MAP_X_BITS  = 9,
  parameter int ADR_W       = 16,
  parameter int RUN_AFTER   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       key,
  input  logic [Y_W-1:0]   ypos,
  input  logic             door_open,
  input  logic [3:0]       map_pixel,
  output logic [ADR_W-1:0] map_adr,
  output logic [X_W-1:0]   player_xpos,
  output logic             direction,
  output logic             busy,
  output logic             blocked
`ifdef PLAYER_RUN_EN
  , output logic           running
`endif
);
  localparam int XW1 = X_W + 1;
  localparam int TW  = $clog2(TICK_CYCLES + 1);
  localparam int LW  = $clog2(MAP_LAT + 1);
  localparam logic [X_W-1:0]   STEP_X   = X_W'(STEP);
  localparam logic [X_W:0]     STEP_W   = XW1'(STEP);
  localparam logic [X_W:0]     XMAX_W   = XW1'(X_MAX);
  localparam logic [X_W-1:0]   XMAX_X   = X_W'(X_MAX);
  localparam logic [LW-1:0]    LAT_LAST = LW'(MAP_LAT - 1);
  localparam logic [TW-1:0]    TICK_LEN = TW'(TICK_CYCLES);
  localparam logic [ADR_W-1:0] XMASK    = ADR_W'((64'd1 << MAP_X_BITS) - 64'd1);

  state_e           state_q, state_d;
  dir_e             dir_q, dir_d, req_q, req_d, req_new;
  logic [X_W-1:0]   xpos_q, xpos_d, tgt_q, tgt_d, tgt_new, tgt_r, tgt_l;
  logic [X_W:0]     sum_r;
  logic [ADR_W-1:0] adr_q, adr_d, adr_new;
  logic [LW-1:0]    lat_q, lat_d;
  logic             blk_q, blk_d, busy_q, busy_d;
  logic             move_key, move_ok, load;
  logic [TW-1:0]    wait_len;
  logic             done;

`ifdef PLAYER_RUN_EN
  localparam int RW    = $clog2(RUN_AFTER + 1);
  localparam int SHORT = ((TICK_CYCLES >> 1) < 1) ? 1 : (TICK_CYCLES >> 1);
  localparam logic [RW-1:0] RUN_SAT   = RW'(RUN_AFTER);
  localparam logic [TW-1:0] SHORT_LEN = TW'(SHORT);
  logic [RW-1:0] run_q, run_d;
  logic          running_q, running_d;
`endif

  // Target clamped to [0, X_MAX]; the extra sum bit catches overflow past X_MAX.
  assign sum_r    = {1'b0, xpos_q} + STEP_W;
  assign tgt_r    = (sum_r > XMAX_W) ? XMAX_X : sum_r[X_W-1:0];
  assign tgt_l    = (xpos_q < STEP_X) ? '0 : xpos_q - STEP_X;
  assign move_key = (key == key_A) || (key == key_D);
  assign req_new  = (key == key_D) ? DIR_RIGHT : DIR_LEFT;
  assign tgt_new  = (req_new == DIR_RIGHT) ? tgt_r : tgt_l;
  assign adr_new  = (ADR_W'(ypos >> MAP_SHIFT) << MAP_X_BITS)
                  | (ADR_W'(tgt_new >> MAP_SHIFT) & XMASK);

  // Reversals may leave a wall tile, but never pass a bound (tgt == xpos).
  assign move_ok  = (tgt_q != xpos_q) &&
                    ((req_q != dir_q) || !tile_blocks(map_pixel, door_open));

  always_comb begin
    state_d  = state_q;
    xpos_d   = xpos_q;
    dir_d    = dir_q;
    req_d    = req_q;
    tgt_d    = tgt_q;
    adr_d    = adr_q;
    lat_d    = lat_q;
    blk_d    = 1'b0;
    load     = 1'b0;
    wait_len = TICK_LEN;
`ifdef PLAYER_RUN_EN
    run_d    = run_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (move_key) begin
          req_d   = req_new;
          tgt_d   = tgt_new;
          adr_d   = adr_new;
          lat_d   = '0;
          state_d = LOOKUP;
        end
`ifdef PLAYER_RUN_EN
        else run_d = '0;
`endif
      end
      LOOKUP: begin
        if (lat_q == LAT_LAST) begin
          dir_d = req_q;
          if (move_ok) xpos_d = tgt_q;
          else         blk_d  = 1'b1;
`ifdef PLAYER_RUN_EN
          if (move_ok && (req_q == dir_q))
            run_d = (run_q == RUN_SAT) ? run_q : run_q + RW'(1);
          else
            run_d = '0;
          if (run_d >= RUN_SAT) wait_len = SHORT_LEN;
`endif
          load    = 1'b1;
          lat_d   = '0;
          state_d = WAIT;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      WAIT:    if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
`ifdef PLAYER_RUN_EN
    running_d = (run_d >= RUN_SAT);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      xpos_q  <= '0;
      dir_q   <= DIR_RIGHT;
      req_q   <= DIR_RIGHT;
      tgt_q   <= '0;
      adr_q   <= '0;
      lat_q   <= '0;
      blk_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xpos_q  <= xpos_d;
      dir_q   <= dir_d;
      req_q   <= req_d;
      tgt_q   <= tgt_d;
      adr_q   <= adr_d;
      lat_q   <= lat_d;
      blk_q   <= blk_d;
      busy_q  <= busy_d;
    end
  end

`ifdef PLAYER_RUN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q     <= '0;
      running_q <= 1'b0;
    end else begin
      run_q     <= run_d;
      running_q <= running_d;
    end
  end
  assign running = running_q;
`endif

  tick_timer #(.W(TW)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .len  (wait_len),
    .done (done)
  );

  assign map_adr     = adr_q;
  assign player_xpos = xpos_q;
  assign direction   = dir_q;
  assign busy        = busy_q;
  assign blocked     = blk_q;
endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: two instances (STEP=1 and STEP=3 with a
// small X_MAX) share stimulus; a per-instance transaction model checks every
// cycle, a vector table and hand sequences check the directed cases.
module tb_player_motion_ctrl;
  import vga_pkg::*;

  localparam int NI = 2;
  localparam int RA = 2;
  int p_step[NI]  = '{1, 3};
  int p_xmax[NI]  = '{2000, 22};
  int p_tick[NI]  = '{4, 3};
  int p_lat[NI]   = '{1, 2};
  int p_short[NI] = '{2, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key = 4'h0;
  logic [9:0]  ypos = 10'd37;
  logic        door_open = 1'b0;
  logic [3:0]  map_pixel = 4'h1;
  logic [15:0] adr[NI];
  logic [10:0] xp[NI];
  logic        dir_o[NI], busy_o[NI], blk_o[NI];
`ifdef PLAYER_RUN_EN
  logic        run_o[NI];
`endif

  int total = 0, bad = 0;
  int bc[NI];

  always #5 clk = ~clk;

  player_motion_ctrl #(.STEP(1), .X_MAX(2000), .TICK_CYCLES(4), .MAP_LAT(1),
                       .RUN_AFTER(RA)) u_a (
    .clk(clk), .rst(rst), .key(key), .ypos(ypos), .door_open(door_open),
    .map_pixel(map_pixel), .map_adr(adr[0]), .player_xpos(xp[0]),
    .direction(dir_o[0]), .busy(busy_o[0]), .blocked(blk_o[0])
`ifdef PLAYER_RUN_EN
    , .running(run_o[0])
`endif
  );

  player_motion_ctrl #(.STEP(3), .X_MAX(22), .TICK_CYCLES(3), .MAP_LAT(2),
                       .RUN_AFTER(RA)) u_b (
    .clk(clk), .rst(rst), .key(key), .ypos(ypos), .door_open(door_open),
    .map_pixel(map_pixel), .map_adr(adr[1]), .player_xpos(xp[1]),
    .direction(dir_o[1]), .busy(busy_o[1]), .blocked(blk_o[1])
`ifdef PLAYER_RUN_EN
    , .running(run_o[1])
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model: one move = one transaction ----------
  int mx[NI], md[NI], madr[NI], mblk[NI], mcnt[NI], mres[NI], mreq[NI], mtgt[NI], mrun[NI];

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      mx[i] = 0; md[i] = 1; madr[i] = 0; mblk[i] = 0;
      mcnt[i] = 0; mres[i] = 0; mreq[i] = 1; mtgt[i] = 0; mrun[i] = 0;
    end
  endtask

  task automatic model_step();
    int yv, wall, ok;
    yv = int'(ypos);
    for (int i = 0; i < NI; i++) begin
      mblk[i] = 0;
      if (mcnt[i] == 0) begin
        if (key == key_A || key == key_D) begin
          mreq[i] = (key == key_D) ? 1 : 0;
          if (mreq[i] == 1) mtgt[i] = (mx[i] + p_step[i] > p_xmax[i]) ? p_xmax[i] : mx[i] + p_step[i];
          else              mtgt[i] = (mx[i] < p_step[i]) ? 0 : mx[i] - p_step[i];
          madr[i] = (((yv / 4) * 512) + ((mtgt[i] / 4) % 512)) % 65536;
          mres[i] = p_lat[i];
          mcnt[i] = p_lat[i] + p_tick[i];
        end else mrun[i] = 0;
      end else begin
        mcnt[i]--;
        mres[i]--;
        if (mres[i] == 0) begin
          wall = (map_pixel == 4'h0 || (map_pixel == 4'h4 && !door_open)) ? 1 : 0;
          ok = (mtgt[i] != mx[i] && (mreq[i] != md[i] || wall == 0)) ? 1 : 0;
          if (ok == 1 && mreq[i] == md[i]) mrun[i] = (mrun[i] >= RA) ? RA : mrun[i] + 1;
          else mrun[i] = 0;
          md[i] = mreq[i];
          if (ok == 1) mx[i] = mtgt[i];
          else mblk[i] = 1;
`ifdef PLAYER_RUN_EN
          if (mrun[i] >= RA) mcnt[i] = p_short[i];
`endif
        end
      end
    end
  endtask

  initial model_reset();
  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  task automatic observe();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d_xpos", i), int'(xp[i]), mx[i]);
      chk($sformatf("u%0d_dir", i), int'(dir_o[i]), md[i]);
      chk($sformatf("u%0d_busy", i), int'(busy_o[i]), (mcnt[i] != 0) ? 1 : 0);
      chk($sformatf("u%0d_blocked", i), int'(blk_o[i]), mblk[i]);
      chk($sformatf("u%0d_adr", i), int'(adr[i]), madr[i]);
`ifdef PLAYER_RUN_EN
      chk($sformatf("u%0d_running", i), int'(run_o[i]), (mrun[i] >= RA) ? 1 : 0);
`endif
      if (blk_o[i]) bc[i]++;
    end
  endtask

  always @(negedge clk) observe();

  // ---------------- directed stimulus -------------------------------------
  typedef struct {
    logic [3:0] k; logic [3:0] pix; logic door; int reps;
    int x; int dir; int blk; int adrx;
  } vec_t;
  vec_t tab[13];

  task automatic step();
    @(negedge clk); #1;
  endtask

  // One move attempt per 6 cycles (MAP_LAT+TICK+1 for both instances).
  task automatic attempts(input logic [3:0] k, input int n);
    for (int j = 0; j < n; j++) begin
`ifdef PLAYER_RUN_EN
      key = 4'h0;  // idle gap keeps run mode out of the directed rows
      step();
`endif
      key = k;
      repeat (6) step();
    end
  endtask

  initial begin
    int tch[4];
    int nch, prev, r, q;
    bc[0] = 0; bc[1] = 0;
    //         key    pix   door reps  x  dir blk adrx   (instance u_a)
    tab[0]  = '{key_D, 4'h1, 1'b0, 1,   1, 1, 0, 0};
    tab[1]  = '{key_D, 4'h1, 1'b0, 1,   2, 1, 0, 0};
    tab[2]  = '{key_D, 4'h1, 1'b0, 1,   3, 1, 0, 0};
    tab[3]  = '{key_D, 4'h1, 1'b0, 7,  10, 1, 0, 2};
    tab[4]  = '{key_D, 4'h0, 1'b0, 2,  10, 1, 2, 2};
    tab[5]  = '{key_A, 4'h0, 1'b0, 1,   9, 0, 0, 2};
    tab[6]  = '{key_A, 4'h0, 1'b0, 1,   9, 0, 1, 2};
    tab[7]  = '{key_D, 4'h1, 1'b0, 1,  10, 1, 0, 2};
    tab[8]  = '{key_D, 4'h4, 1'b0, 1,  10, 1, 1, 2};
    tab[9]  = '{key_D, 4'h4, 1'b1, 1,  11, 1, 0, 2};
    tab[10] = '{key_D, 4'hF, 1'b0, 1,  12, 1, 0, 3};
    tab[11] = '{key_A, 4'h1, 1'b0, 12,  0, 0, 0, 0};
    tab[12] = '{key_A, 4'h1, 1'b0, 2,   0, 0, 2, 0};

    repeat (3) step();
    chk("reset_xpos", int'(xp[0]), 0);
    chk("reset_dir", int'(dir_o[0]), 1);
    chk("reset_busy", int'(busy_o[0]), 0);
    chk("reset_blocked", int'(blk_o[0]), 0);
    chk("reset_adr", int'(adr[0]), 0);
    rst = 1'b0;

    for (int v = 0; v < 13; v++) begin
      map_pixel = tab[v].pix;
      door_open = tab[v].door;
      bc[0] = 0; bc[1] = 0;
      attempts(tab[v].k, tab[v].reps);
      chk($sformatf("vec%0d_xpos", v), int'(xp[0]), tab[v].x);
      chk($sformatf("vec%0d_dir", v), int'(dir_o[0]), tab[v].dir);
      chk($sformatf("vec%0d_blocks", v), bc[0], tab[v].blk);
      chk($sformatf("vec%0d_adrx", v), int'(adr[0][8:0]), tab[v].adrx);
    end
    // STEP=3 instance at the left bound: two blocked attempts in the last row
    chk("left_bound_b_xpos", int'(xp[1]), 0);
    chk("left_bound_b_blocks", bc[1], 2);

    // Right bound, STEP=3: 0 -> 21 in 7 moves, then 22 = X_MAX, then blocked
    map_pixel = 4'h1;
    attempts(key_D, 7);
    chk("right_bound_pre", int'(xp[1]), 21);
    attempts(key_D, 1);
    chk("right_bound_hit", int'(xp[1]), 22);
    bc[1] = 0;
    attempts(key_D, 1);
    chk("right_bound_stay", int'(xp[1]), 22);
    chk("right_bound_blocks", bc[1], 1);

    // Reset in the middle of a move
    rst = 1'b1; step(); rst = 1'b0;
    attempts(key_D, 5);
    chk("midrst_pre_xpos", int'(xp[0]), 5);
    key = key_D;
    step();
    chk("midrst_in_lookup", int'(busy_o[0]), 1);
    rst = 1'b1;
    #1;
    chk("midrst_xpos", int'(xp[0]), 0);
    chk("midrst_dir", int'(dir_o[0]), 1);
    chk("midrst_busy", int'(busy_o[0]), 0);
    chk("midrst_blocked", int'(blk_o[0]), 0);
    chk("midrst_b_xpos", int'(xp[1]), 0);
    step();
    rst = 1'b0; key = 4'h0;
    step();

`ifdef PLAYER_RUN_EN
    // Run mode: held key_D, gaps between xpos changes are 6, 4, 4
    map_pixel = 4'h1;
    key = key_D;
    nch = 0; prev = int'(xp[0]);
    for (int c = 0; c < 40; c++) begin
      step();
      if (int'(xp[0]) != prev && nch < 4) begin
        tch[nch] = c; nch++;
      end
      prev = int'(xp[0]);
    end
    chk("run_moves_seen", nch, 4);
    chk("run_gap1", tch[1] - tch[0], 6);
    chk("run_gap2", tch[2] - tch[1], 4);
    chk("run_gap3", tch[3] - tch[2], 4);
    chk("run_active", int'(run_o[0]), 1);
    key = 4'h0;
    repeat (8) step();
    chk("run_cleared", int'(run_o[0]), 0);
`else
    tch[0] = 0; nch = 0;
`endif

    // Randomized phase, checked every cycle against the model
    for (int c = 0; c < 2000; c++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)      key = key_D;
      else if (r < 7) key = key_A;
      else            key = 4'($urandom_range(0, 15));
      q = int'($urandom_range(0, 9));
      if (q < 3)      map_pixel = 4'h0;
      else if (q < 5) map_pixel = 4'h4;
      else            map_pixel = 4'($urandom_range(0, 15));
      door_open = 1'($urandom_range(0, 1));
      ypos = 10'($urandom_range(0, 1023));
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
